io_channel_ctrl: RTL and testbench
==================================

# io_channel_ctrl

Parametrised multi-channel I/O controller for the accumulator processor. It replaces the single fixed INPR/OUTR pair with NCH independent channels. Each channel has a buffered input path and a single-entry output register, together with FGI/FGO-style flags. It provides an interrupt-enable flip-flop and a prioritised interrupt request to the control unit, and sits between the datapath's I/O instruction decode and the external devices.

## Interface
- DATA_W, 8, channel data width (INPR/OUTR width)
- NCH, 2, number of channels, 1..8
- FIFO_DEPTH, 4, input FIFO entries per channel, power of two, >= 2
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-low
- dev_in_data  in  NCH*DATA_W  device input bytes, channel c at [c*DATA_W +: DATA_W]
- dev_in_stb  in  NCH  one-cycle strobe per device: byte valid
- dev_out_data  out  NCH*DATA_W  output register contents
- dev_out_valid  out  NCH  output register holds an unsent byte
- dev_out_ready  in  NCH  device accepts the byte
- ch_sel  in  CH_W  channel addressed by CPU ops, CH_W = max(1, clog2(NCH))
- inp_rd  in  1  INP: pop head of the selected FIFO
- inp_data  out  DATA_W  head of the selected FIFO (first-word fall-through), 0 when empty
- out_wr  in  1  OUT: load out_data into the selected output register
- out_data  in  DATA_W  byte from AC
- ovr_clr  in  1  clear the overrun flag of the selected channel
- ien_set / ien_clr  in  1  ION / IOF
- irq_ack  in  1  control unit enters the interrupt cycle
- fgi  out  NCH  input FIFO non-empty
- fgo  out  NCH  output register empty
- ovr  out  NCH  sticky input overrun
- ien  out  1  interrupt enable
- irq  out  1  interrupt request
- irq_ch  out  CH_W  channel selected for service

## Operation
- Reset (rst=0 at edge): all FIFOs empty, fgi=0, fgo=all 1, dev_out_valid=0, dev_out_data=0, ovr=0, ien=0, irq=0, irq_ch=0, RR pointer=0.
- Input push: dev_in_stb[c] while FIFO c is not full writes the byte. If the FIFO is full and is not popped in the same cycle, the byte is dropped and ovr[c] is set.
- Full FIFO with push and pop on the same cycle: both happen, and the count is unchanged. Empty FIFO with push and pop: the pop is ignored and the push happens.
- inp_rd on an empty channel leaves the pointers unchanged and inp_data reads 0. Pointers wrap modulo FIFO_DEPTH, and the count is held in clog2(FIFO_DEPTH)+1 bits.
- Output: out_wr with fgo[ch_sel]=1 loads the register and sets dev_out_valid. out_wr with fgo=0 is ignored and leaves the held byte intact.
- A dev_out_valid & dev_out_ready handshake clears valid on the next edge. A same-cycle out_wr on that busy channel is ignored, because fgo was 0 at that edge.
- ovr_clr together with an overrun event on the same channel in the same cycle leaves ovr set.
- Interrupt enable: ien_clr beats ien_set. irq_ack clears ien and beats ien_set.
- Interrupt request: irq = ien & |(fgi | fgo). irq_ch is the pending channel selected by the priority scheme in Configuration. A channel is pending when fgi[c] | fgo[c].
- An out-of-range ch_sel (>= NCH) ignores all writes, and inp_data reads 0.

## Timing
- All state updates on the rising clk edge.
- fgi, fgo, ovr, ien and dev_out_valid are registered outputs.
- inp_data, irq and irq_ch are combinational from registers. There is no combinational path from inputs to these outputs other than ch_sel to inp_data.
- A byte strobed at edge N is visible on inp_data and fgi after edge N.
- A byte popped at edge N: the next entry appears after edge N.
- out_wr at edge N raises dev_out_valid and drops fgo after edge N.
- irq_ack at edge N drops ien and irq after edge N.

## Configuration
- IO_PRIORITY_RR_EN defined: round-robin priority. irq_ch is the first pending channel at or after the RR pointer, searching cyclically. On irq_ack the pointer becomes irq_ch+1 mod NCH.
- IO_PRIORITY_RR_EN undefined: fixed priority. irq_ch is the lowest-numbered pending channel. The pointer logic is absent.

## Structure
- Shared package io_pkg:
  - CH_W and count-width helper functions (clog2-based)
  - channel flag struct {fgi, fgo, ovr}
  - reset constants
- Sub-module io_sync_fifo, one per channel via generate:
  - parameters DATA_W and DEPTH
  - ports push, pop, din, dout, empty, full
  - first-word fall-through, with simultaneous push and pop at full allowed

## Test plan
- Reset, then check defaults: fgo=2'b11, fgi=0, ien=0, irq=0, inp_data=0.
- Fill and overrun:
  - stimulus: strobe 0x11..0x15 on ch0 with DEPTH=4
  - response: fifo holds 0x11..0x14, ovr[0]=1, 0x15 lost
  - stimulus: four inp_rd
  - response: inp_data returns 0x11,0x12,0x13,0x14, then fgi[0]=0
- Output handshake:
  - stimulus: out_wr 0xA5 on ch1, then out_wr 0x5A while busy
  - response: dev_out_data ch1=0xA5, second write ignored
  - stimulus: dev_out_ready=1 for one cycle
  - response: fgo[1]=1
- Interrupt:
  - stimulus: ien_set, then byte on ch1
  - response: irq=1, irq_ch=1
  - stimulus: irq_ack plus ien_set in the same cycle
  - response: ien=0, irq=0
- Priority, with ch0 and ch1 both pending and repeated ack/ION:
  - fixed priority: irq_ch always 0
  - IO_PRIORITY_RR_EN: irq_ch alternates 0,1,0
- Full FIFO push+pop in the same cycle: count stays 4, no overrun, head advances.

Source files
------------

// File: rtl/io_pkg.sv
// Shared types, width helpers and reset values for the multi-channel I/O controller.
package io_pkg;

  function automatic int unsigned ch_width(input int unsigned nch);
    return (nch <= 1) ? 1 : $clog2(nch);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic fgi;
    logic fgo;
    logic ovr;
  } io_flags_t;

  localparam logic IEN_RST   = 1'b0;
  localparam logic OVR_RST   = 1'b0;
  localparam logic VALID_RST = 1'b0;
  localparam io_flags_t FLAGS_RST = '{fgi: 1'b0, fgo: 1'b1, ovr: 1'b0};

endpackage

// File: rtl/io_sync_fifo.sv
// First-word fall-through synchronous FIFO; push and pop together are allowed when full.
module io_sync_fifo
  import io_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees the slot the push needs, so a full FIFO still accepts on a pop cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/io_channel_ctrl.sv
// NCH-channel I/O controller with FGI/FGO/overrun flags and interrupt request.
// Define IO_PRIORITY_RR_EN for round-robin interrupt priority; fixed priority otherwise.
module io_channel_ctrl
  import io_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned NCH        = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CH_W       = ch_width(NCH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH*DATA_W-1:0] dev_in_data,
  input  logic [NCH-1:0]        dev_in_stb,
  output logic [NCH*DATA_W-1:0] dev_out_data,
  output logic [NCH-1:0]        dev_out_valid,
  input  logic [NCH-1:0]        dev_out_ready,
  input  logic [CH_W-1:0]       ch_sel,
  input  logic                  inp_rd,
  output logic [DATA_W-1:0]     inp_data,
  input  logic                  out_wr,
  input  logic [DATA_W-1:0]     out_data,
  input  logic                  ovr_clr,
  input  logic                  ien_set,
  input  logic                  ien_clr,
  input  logic                  irq_ack,
  output logic [NCH-1:0]        fgi,
  output logic [NCH-1:0]        fgo,
  output logic [NCH-1:0]        ovr,
  output logic                  ien,
  output logic                  irq,
  output logic [CH_W-1:0]       irq_ch
);

  logic [NCH-1:0]    sel, empty, full, pending;
  logic [DATA_W-1:0] fifo_dout [NCH];
  io_flags_t [NCH-1:0] flags;
  logic              ien_q;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic              pop, push, ovr_evt;
    logic              ovr_q, valid_q;
    logic [DATA_W-1:0] out_q;

    // Out-of-range ch_sel matches no channel, so every CPU write is dropped.
    assign sel[c]  = (ch_sel == CH_W'(c));
    assign pop     = inp_rd & sel[c];
    assign push    = dev_in_stb[c] & (~full[c] | pop);
    assign ovr_evt = dev_in_stb[c] & full[c] & ~pop;

    io_sync_fifo #(
      .DATA_W(DATA_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push),
      .pop  (pop),
      .din  (dev_in_data[c*DATA_W +: DATA_W]),
      .dout (fifo_dout[c]),
      .empty(empty[c]),
      .full (full[c])
    );

    always_ff @(posedge clk) begin
      if (!rst) begin
        ovr_q   <= OVR_RST;
        valid_q <= VALID_RST;
        out_q   <= '0;
      end else begin
        ovr_q <= (ovr_q & ~(ovr_clr & sel[c])) | ovr_evt;
        if (out_wr && sel[c] && !valid_q) begin
          out_q   <= out_data;
          valid_q <= 1'b1;
        end else if (valid_q && dev_out_ready[c]) begin
          valid_q <= 1'b0;
        end
      end
    end

    assign flags[c] = '{fgi: ~empty[c], fgo: ~valid_q, ovr: ovr_q};
    assign fgi[c]   = flags[c].fgi;
    assign fgo[c]   = flags[c].fgo;
    assign ovr[c]   = flags[c].ovr;
    assign pending[c] = flags[c].fgi | flags[c].fgo;
    assign dev_out_valid[c] = valid_q;
    assign dev_out_data[c*DATA_W +: DATA_W] = out_q;
  end

  always_comb begin
    inp_data = '0;
    for (int c = 0; c < NCH; c++) begin
      if (sel[c]) inp_data = fifo_dout[c];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ien_q <= IEN_RST;
    end else if (ien_clr || irq_ack) begin
      ien_q <= 1'b0;
    end else if (ien_set) begin
      ien_q <= 1'b1;
    end
  end

  assign ien = ien_q;
  assign irq = ien_q & (|pending);

`ifdef IO_PRIORITY_RR_EN
  logic [CH_W-1:0] rr_q;

  // Scan from the farthest slot back to the pointer so the nearest pending channel wins.
  always_comb begin
    int unsigned idx;
    idx    = 0;
    irq_ch = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = (int'(rr_q) + k) % NCH;
      if (pending[idx]) irq_ch = CH_W'(idx);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_q <= '0;
    end else if (irq_ack) begin
      rr_q <= (irq_ch == CH_W'(NCH - 1)) ? '0 : irq_ch + 1'b1;
    end
  end
`else
  always_comb begin
    irq_ch = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (pending[k]) irq_ch = CH_W'(k);
    end
  end
`endif

endmodule

// File: tb/tb_io_channel_ctrl.sv
// Self-checking bench for io_channel_ctrl: directed scenarios plus randomized traffic vs a queue model.
module tb_io_channel_ctrl;

  localparam int DATA_W = 8;
  localparam int NCH    = 2;
  localparam int DEPTH  = 4;
  localparam int CH_W   = 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NCH*DATA_W-1:0] dev_in_data;
  logic [NCH-1:0]        dev_in_stb;
  logic [NCH*DATA_W-1:0] dev_out_data;
  logic [NCH-1:0]        dev_out_valid;
  logic [NCH-1:0]        dev_out_ready;
  logic [CH_W-1:0]       ch_sel;
  logic                  inp_rd;
  logic [DATA_W-1:0]     inp_data;
  logic                  out_wr;
  logic [DATA_W-1:0]     out_data;
  logic                  ovr_clr, ien_set, ien_clr, irq_ack;
  logic [NCH-1:0]        fgi, fgo, ovr;
  logic                  ien, irq;
  logic [CH_W-1:0]       irq_ch;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  io_channel_ctrl #(
    .DATA_W    (DATA_W),
    .NCH       (NCH),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .dev_in_data  (dev_in_data),
    .dev_in_stb   (dev_in_stb),
    .dev_out_data (dev_out_data),
    .dev_out_valid(dev_out_valid),
    .dev_out_ready(dev_out_ready),
    .ch_sel       (ch_sel),
    .inp_rd       (inp_rd),
    .inp_data     (inp_data),
    .out_wr       (out_wr),
    .out_data     (out_data),
    .ovr_clr      (ovr_clr),
    .ien_set      (ien_set),
    .ien_clr      (ien_clr),
    .irq_ack      (irq_ack),
    .fgi          (fgi),
    .fgo          (fgo),
    .ovr          (ovr),
    .ien          (ien),
    .irq          (irq),
    .irq_ch       (irq_ch)
  );

  // Reference model: circular buffer + count per channel, output byte/busy flag, enable, pointer.
  logic [DATA_W-1:0] m_mem [NCH][DEPTH];
  int                m_head [NCH];
  int                m_cnt [NCH];
  logic [NCH-1:0]    m_ovr, m_valid;
  logic [DATA_W-1:0] m_out [NCH];
  logic              m_ien;
  int                m_rr;

  function automatic logic m_pending(input int c);
    return (m_cnt[c] > 0) || !m_valid[c];
  endfunction

  function automatic int m_irq_ch();
    for (int k = 0; k < NCH; k++) begin
`ifdef IO_PRIORITY_RR_EN
      if (m_pending((m_rr + k) % NCH)) return (m_rr + k) % NCH;
`else
      if (m_pending(k)) return k;
`endif
    end
    return 0;
  endfunction

  function automatic logic m_irq();
    logic any;
    any = 1'b0;
    for (int c = 0; c < NCH; c++) any |= m_pending(c);
    return m_ien && any;
  endfunction

  function automatic logic [DATA_W-1:0] m_inp();
    int s;
    s = int'(ch_sel);
    if (s < NCH && m_cnt[s] > 0) return m_mem[s][m_head[s]];
    return '0;
  endfunction

  function automatic logic [NCH-1:0] m_fgi();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c] = (m_cnt[c] > 0);
    return v;
  endfunction

  function automatic logic [NCH*DATA_W-1:0] m_outbus();
    logic [NCH*DATA_W-1:0] v;
    for (int c = 0; c < NCH; c++) v[c*DATA_W +: DATA_W] = m_out[c];
    return v;
  endfunction

  task automatic idle();
    dev_in_stb = '0; dev_out_ready = '0; inp_rd = 0; out_wr = 0;
    ovr_clr = 0; ien_set = 0; ien_clr = 0; irq_ack = 0;
  endtask

  // Advance model from the pre-edge inputs, then clock the DUT and settle.
  task automatic cycle();
    int  ich;
    logic sel, pop, full, evt;
    ich = m_irq_ch();
    if (!rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_head[c] = 0; m_cnt[c] = 0; m_out[c] = '0;
      end
      m_ovr = '0; m_valid = '0; m_ien = 0; m_rr = 0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        sel  = (int'(ch_sel) == c);
        pop  = inp_rd && sel && (m_cnt[c] > 0);
        full = (m_cnt[c] == DEPTH);
        evt  = 0;
        if (pop) begin
          m_head[c] = (m_head[c] + 1) % DEPTH;
          m_cnt[c]--;
        end
        if (dev_in_stb[c]) begin
          if (!full || pop) begin
            m_mem[c][(m_head[c] + m_cnt[c]) % DEPTH] = dev_in_data[c*DATA_W +: DATA_W];
            m_cnt[c]++;
          end else evt = 1;
        end
        m_ovr[c] = (m_ovr[c] && !(ovr_clr && sel)) || evt;
        if (out_wr && sel && !m_valid[c]) begin
          m_out[c] = out_data; m_valid[c] = 1;
        end else if (m_valid[c] && dev_out_ready[c]) m_valid[c] = 0;
      end
      if (ien_clr || irq_ack) m_ien = 0;
      else if (ien_set) m_ien = 1;
`ifdef IO_PRIORITY_RR_EN
      if (irq_ack) m_rr = (ich + 1) % NCH;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle(); rst = 0; ch_sel = '0; out_data = '0; dev_in_data = '0;
    cycle(); cycle();
    rst = 1;
    n_total++; if (fgo !== 2'b11) $display("FAIL reset_fgo got %b exp 11", fgo); else n_pass++;
    n_total++; if (fgi !== 2'b00) $display("FAIL reset_fgi got %b exp 00", fgi); else n_pass++;
    n_total++; if (ien !== 1'b0) $display("FAIL reset_ien got %b exp 0", ien); else n_pass++;
    n_total++; if (irq !== 1'b0) $display("FAIL reset_irq got %b exp 0", irq); else n_pass++;
    n_total++; if (inp_data !== 8'h00) $display("FAIL reset_inp got %h exp 00", inp_data);
    else n_pass++;
    n_total++; if (ovr !== 2'b00 || dev_out_valid !== 2'b00 || irq_ch !== 1'b0)
      $display("FAIL reset_misc got ovr=%b valid=%b irq_ch=%0d exp 00/00/0",
               ovr, dev_out_valid, irq_ch);
    else n_pass++;
  endtask

  task automatic test_fill_overrun();
    idle(); ch_sel = 0;
    for (int i = 0; i < 5; i++) begin
      dev_in_stb = 2'b01; dev_in_data[7:0] = 8'(8'h11 + i);
      cycle();
    end
    idle();
    n_total++; if (ovr[0] !== 1'b1) $display("FAIL fill_ovr got %b exp 1", ovr[0]); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (inp_data !== 8'(8'h11 + i) || inp_data !== m_inp())
        $display("FAIL fill_pop%0d got %h exp %h", i, inp_data, 8'(8'h11 + i));
      else n_pass++;
      inp_rd = 1; cycle();
    end
    idle();
    n_total++; if (fgi[0] !== 1'b0) $display("FAIL fill_drained got %b exp 0", fgi[0]);
    else n_pass++;
    n_total++; if (inp_data !== 8'h00) $display("FAIL empty_rd got %h exp 00", inp_data);
    else n_pass++;
    ovr_clr = 1; cycle(); idle();
    n_total++; if (ovr[0] !== 1'b0) $display("FAIL ovr_clr got %b exp 0", ovr[0]); else n_pass++;
  endtask

  task automatic test_output();
    idle(); ch_sel = 1; out_wr = 1; out_data = 8'hA5; cycle();
    n_total++; if (dev_out_data[15:8] !== 8'hA5 || dev_out_valid[1] !== 1'b1 || fgo[1] !== 1'b0)
      $display("FAIL out_load got %h v=%b fgo=%b exp a5 1 0",
               dev_out_data[15:8], dev_out_valid[1], fgo[1]);
    else n_pass++;
    out_data = 8'h5A; cycle();
    n_total++; if (dev_out_data[15:8] !== 8'hA5)
      $display("FAIL out_busy got %h exp a5", dev_out_data[15:8]);
    else n_pass++;
    idle(); dev_out_ready = 2'b10; cycle(); idle();
    n_total++; if (fgo[1] !== 1'b1) $display("FAIL out_hs got %b exp 1", fgo[1]); else n_pass++;
    out_wr = 1; out_data = 8'h3C; cycle();
    out_data = 8'h77; dev_out_ready = 2'b10; cycle(); idle();
    n_total++; if (dev_out_valid[1] !== 1'b0 || dev_out_data[15:8] !== 8'h3C)
      $display("FAIL out_hs_wr got v=%b d=%h exp 0 3c", dev_out_valid[1], dev_out_data[15:8]);
    else n_pass++;
  endtask

  task automatic test_interrupt();
    idle(); ch_sel = 0; out_wr = 1; out_data = 8'h99; cycle();
    idle(); ien_set = 1; cycle();
    idle(); dev_in_stb = 2'b10; dev_in_data[15:8] = 8'hC3; cycle(); idle();
    n_total++; if (irq !== 1'b1 || irq_ch !== 1'b1)
      $display("FAIL irq_raise got irq=%b ch=%0d exp 1 1", irq, irq_ch);
    else n_pass++;
    irq_ack = 1; ien_set = 1; cycle(); idle();
    n_total++; if (ien !== 1'b0 || irq !== 1'b0)
      $display("FAIL irq_ack got ien=%b irq=%b exp 0 0", ien, irq);
    else n_pass++;
    ien_set = 1; ien_clr = 1; cycle(); idle();
    n_total++; if (ien !== 1'b0) $display("FAIL ien_clr_wins got %b exp 0", ien); else n_pass++;
  endtask

  task automatic test_priority();
    int exp_seq [3];
`ifdef IO_PRIORITY_RR_EN
    exp_seq = '{0, 1, 0};
`else
    exp_seq = '{0, 0, 0};
`endif
    idle(); dev_out_ready = 2'b01; cycle(); idle();
    for (int i = 0; i < 3; i++) begin
      ien_set = 1; cycle(); idle();
      n_total++;
      if (irq !== 1'b1 || int'(irq_ch) !== exp_seq[i] || int'(irq_ch) !== m_irq_ch())
        $display("FAIL prio%0d got irq=%b ch=%0d exp 1 %0d", i, irq, irq_ch, exp_seq[i]);
      else n_pass++;
      irq_ack = 1; cycle(); idle();
    end
  endtask

  task automatic test_full_push_pop();
    idle(); ch_sel = 1;
    for (int i = 0; i < 8; i++) begin
      if (m_cnt[1] < DEPTH) begin
        dev_in_stb = 2'b10; dev_in_data[15:8] = 8'(8'h40 + i); cycle();
      end
    end
    idle(); dev_in_stb = 2'b10; dev_in_data[15:8] = 8'hEE; inp_rd = 1; cycle(); idle();
    n_total++; if (ovr[1] !== 1'b0 || inp_data !== m_inp() || fgi[1] !== 1'b1)
      $display("FAIL full_pp got ovr=%b head=%h exp 0 %h", ovr[1], inp_data, m_inp());
    else n_pass++;
    dev_in_stb = 2'b10; dev_in_data[15:8] = 8'hDD; cycle(); idle();
    n_total++; if (ovr[1] !== 1'b1) $display("FAIL full_still got %b exp 1", ovr[1]);
    else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      n_total++;
      if (inp_data !== m_inp()) $display("FAIL full_drain%0d got %h exp %h", i, inp_data, m_inp());
      else n_pass++;
      inp_rd = 1; cycle();
    end
    idle();
    n_total++; if (fgi[1] !== 1'b0) $display("FAIL full_empty got %b exp 0", fgi[1]); else n_pass++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      dev_in_stb    = NCH'($urandom);
      dev_in_data   = (NCH*DATA_W)'($urandom);
      dev_out_ready = NCH'($urandom);
      ch_sel        = CH_W'($urandom);
      inp_rd        = ($urandom_range(0, 1) == 1);
      out_wr        = ($urandom_range(0, 2) == 0);
      out_data      = DATA_W'($urandom);
      ovr_clr       = ($urandom_range(0, 5) == 0);
      ien_set       = ($urandom_range(0, 3) == 0);
      ien_clr       = ($urandom_range(0, 7) == 0);
      irq_ack       = ($urandom_range(0, 7) == 0);
      cycle();
      n_total++; if (inp_data !== m_inp())
        $display("FAIL rnd%0d inp got %h exp %h", n, inp_data, m_inp()); else n_pass++;
      n_total++; if (fgi !== m_fgi() || fgo !== ~m_valid || ovr !== m_ovr)
        $display("FAIL rnd%0d flags got %b/%b/%b exp %b/%b/%b",
                 n, fgi, fgo, ovr, m_fgi(), ~m_valid, m_ovr); else n_pass++;
      n_total++; if (dev_out_valid !== m_valid || dev_out_data !== m_outbus())
        $display("FAIL rnd%0d out got %b %h exp %b %h",
                 n, dev_out_valid, dev_out_data, m_valid, m_outbus()); else n_pass++;
      n_total++; if (ien !== m_ien || irq !== m_irq() || int'(irq_ch) !== m_irq_ch())
        $display("FAIL rnd%0d irq got %b %b %0d exp %b %b %0d",
                 n, ien, irq, irq_ch, m_ien, m_irq(), m_irq_ch()); else n_pass++;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fill_overrun();
    test_output();
    test_interrupt();
    test_priority();
    test_full_push_pop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
